// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings and
// the default parameter values used by dmem_arb.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int WIDE_DEF  = 32;
    localparam int BURST_DEF = 4;

endpackage

// File: rtl/dmem_arb_mux2.sv
// Generic two-input multiplexer library part (a when sel=0, b when sel=1).
module mux2 #(
    parameter int W = 1
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/dmem_arb.sv
// Two-port data-memory arbiter: CPU (port 0) and coprocessor/DMA (port 1)
// share one memory with combinational read and clocked write. Ownership is
// held in a registered FSM; a burst counter bounds how long one port may keep
// the memory while the other waits, and a last-owner bit breaks ties.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int wide  = WIDE_DEF,
    parameter int burst = BURST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            r0_req,
    input  logic            r0_we,
    input  logic [31:0]     r0_addr,
    input  logic [wide-1:0] r0_wd,
    output logic            r0_gnt,
    output logic [wide-1:0] r0_rd,
    input  logic            r1_req,
    input  logic            r1_we,
    input  logic [31:0]     r1_addr,
    input  logic [wide-1:0] r1_wd,
    output logic            r1_gnt,
    output logic [wide-1:0] r1_rd,
    output logic            hold,
    output logic            mem_we,
    output logic [31:0]     mem_a,
    output logic [wide-1:0] mem_d,
    input  logic [wide-1:0] mem_q
);

    // Last counter value before the owner must yield to a waiting port.
    localparam logic [7:0] CNT_MAX = 8'(burst - 1);

    state_t            state;
    logic              last;
    logic [7:0]        cnt;

    logic              sel;
    logic              active;
    logic              req_sel;
    logic              we_sel;
    logic [31:0]       addr_sel;
    logic [wide-1:0]   wd_sel;
    logic              other_req;
    state_t            other_own;

    // sel picks port 1 only while it owns; everything else defaults to port 0.
    assign sel       = (state == OWN1);
    assign active    = (state != IDLE);
    assign other_req = sel ? r0_req : r1_req;
    assign other_own = sel ? OWN0 : OWN1;

    mux2 #(.W(1)) u_mux_req (
        .sel (sel),
        .a   (r0_req),
        .b   (r1_req),
        .y   (req_sel)
    );

    mux2 #(.W(1)) u_mux_we (
        .sel (sel),
        .a   (r0_we),
        .b   (r1_we),
        .y   (we_sel)
    );

    mux2 #(.W(32)) u_mux_addr (
        .sel (sel),
        .a   (r0_addr),
        .b   (r1_addr),
        .y   (addr_sel)
    );

    mux2 #(.W(wide)) u_mux_wd (
        .sel (sel),
        .a   (r0_wd),
        .b   (r1_wd),
        .y   (wd_sel)
    );

    // The memory port is quiet in IDLE; a write needs the owner to be requesting.
    assign mem_we = active & req_sel & we_sel;
    assign mem_a  = active ? addr_sel : '0;
    assign mem_d  = active ? wd_sel   : '0;

    // Grants decode straight from the state register, so reset clears them at once.
    assign r0_gnt = (state == OWN0);
    assign r1_gnt = (state == OWN1);
    assign r0_rd  = r0_gnt ? mem_q : '0;
    assign r1_rd  = r1_gnt ? mem_q : '0;
    assign hold   = r0_req & ~r0_gnt;

    // Ownership FSM with tie-break bit and burst counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (r0_req && r1_req) begin
                        state <= last ? OWN0 : OWN1;
                    end else if (r0_req) begin
                        state <= OWN0;
                    end else if (r1_req) begin
                        state <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (!req_sel) begin
                        // Owner released: hand over directly or fall back to IDLE.
                        last  <= sel;
                        cnt   <= '0;
                        state <= other_req ? other_own : IDLE;
                    end else if (other_req && (cnt == CNT_MAX)) begin
                        // Burst exhausted with a waiter: switch right after this access.
                        last  <= sel;
                        cnt   <= '0;
                        state <= other_own;
                    end else if (cnt != CNT_MAX) begin
                        // Saturating count keeps a lone requester from being preempted.
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// Scenario bench for dmem_arb: a behavioural memory, per-scenario tasks that
// push expected per-cycle results to a scoreboard queue while driving stimulus
// and pop/compare them against the DUT at the falling edge.
module tb_dmem_arb;

    localparam logic [31:0] P40 = 32'hA000_0010;  // initial contents at 0x40
    localparam logic [31:0] P80 = 32'hA000_0020;  // initial contents at 0x80
    localparam logic [31:0] P20 = 32'hA000_0008;  // initial contents at 0x20

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r0_wd, r1_addr, r1_wd;
    logic        r0_gnt, r1_gnt, hold, mem_we;
    logic [31:0] r0_rd, r1_rd, mem_a, mem_d, mem_q;

    logic [31:0] mem [0:255];
    logic        mem_init = 1'b0;
    int          wr_count = 0;

    typedef struct {
        logic        g0;
        logic        g1;
        logic        hd;
        logic        cd;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] ma;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    dmem_arb dut (
        .clk     (clk),
        .rst     (rst),
        .r0_req  (r0_req),
        .r0_we   (r0_we),
        .r0_addr (r0_addr),
        .r0_wd   (r0_wd),
        .r0_gnt  (r0_gnt),
        .r0_rd   (r0_rd),
        .r1_req  (r1_req),
        .r1_we   (r1_we),
        .r1_addr (r1_addr),
        .r1_wd   (r1_wd),
        .r1_gnt  (r1_gnt),
        .r1_rd   (r1_rd),
        .hold    (hold),
        .mem_we  (mem_we),
        .mem_a   (mem_a),
        .mem_d   (mem_d),
        .mem_q   (mem_q)
    );

    always #5 clk = ~clk;

    // Memory: word-indexed, combinational read, write on the rising edge.
    assign mem_q = mem[mem_a[9:2]];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'hA000_0000 | 32'(k);
            mem_init <= 1'b1;
        end else if (mem_we) begin
            mem[mem_a[9:2]] <= mem_d;
            wr_count <= wr_count + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got still running, required finished");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_req = 0; r0_we = 0; r0_addr = '0; r0_wd = '0;
        r1_req = 0; r1_we = 0; r1_addr = '0; r1_wd = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_exp(input logic g0, input logic g1, input logic hd, input logic cd,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input logic [31:0] ma);
        exp_t e;
        e.g0 = g0; e.g1 = g1; e.hd = hd; e.cd = cd;
        e.rd0 = rd0; e.rd1 = rd1; e.ma = ma;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #2;
        checks++;
        if ({r0_gnt, r1_gnt, mem_we, hold, mem_a, mem_d, r0_rd, r1_rd} !== 132'd0)
            $display("FAIL reset_outputs: got g0=%b g1=%b we=%b hold=%b a=%h d=%h, required all zero",
                     r0_gnt, r1_gnt, mem_we, hold, mem_a, mem_d);
        else passed++;
        r0_req = 1; r1_req = 1; r0_we = 1; r0_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({r0_gnt, r1_gnt, mem_we, hold} !== 4'b0001)
            $display("FAIL reset_held: got g0/g1/we/hold=%b, required 0001", {r0_gnt, r1_gnt, mem_we, hold});
        else passed++;
    endtask

    task automatic test_write_read();
        exp_t e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            case (i)
                0: begin
                    r0_req = 1; r0_we = 1; r0_addr = 32'h10; r0_wd = 32'hDEADBEEF;
                    push_exp(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
                end
                1: push_exp(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h10);
                2: begin
                    r0_we = 0;
                    push_exp(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 32'h10);
                end
                3: begin
                    r0_req = 0;
                    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
                end
                default: push_exp(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
            endcase
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({r0_gnt, r1_gnt, hold} !== {e.g0, e.g1, e.hd})
                $display("FAIL wr_grant c%0d: got g0/g1/hold=%b, required %b", i,
                         {r0_gnt, r1_gnt, hold}, {e.g0, e.g1, e.hd});
            else passed++;
            if (e.cd) begin
                checks++;
                if ({r0_rd, r1_rd, mem_a} !== {e.rd0, e.rd1, e.ma})
                    $display("FAIL wr_data c%0d: got rd0=%h rd1=%h a=%h, required rd0=%h rd1=%h a=%h",
                             i, r0_rd, r1_rd, mem_a, e.rd0, e.rd1, e.ma);
                else passed++;
            end
            if (i == 1) begin
                checks++;
                if ({mem_we, mem_a, mem_d} !== {1'b1, 32'h10, 32'hDEADBEEF})
                    $display("FAIL wr_access: got we=%b a=%h d=%h, required we=1 a=00000010 d=deadbeef",
                             mem_we, mem_a, mem_d);
                else passed++;
            end
            if (i == 4) begin
                checks++;
                if ({mem_we, mem_d} !== 33'd0)
                    $display("FAIL idle_port: got we=%b d=%h, required we=0 d=0", mem_we, mem_d);
                else passed++;
            end
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF)
            $display("FAIL wr_commit: got mem[0x10]=%h, required deadbeef", mem[4]);
        else passed++;
    endtask

    task automatic test_tie();
        exp_t e;
        logic [5:0] r0v = 6'b000011, r1v = 6'b001111;
        logic [5:0] g0v = 6'b000110, g1v = 6'b011000, hdv = 6'b000001;
        logic [5:0] cdv = 6'b101011;
        do_reset();
        r0_addr = 32'h40; r1_addr = 32'h80;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_cycle();
            r0_req = r0v[i]; r1_req = r1v[i];
            push_exp(g0v[i], g1v[i], hdv[i], cdv[i], g0v[i] ? P40 : 32'h0, g1v[i] ? P80 : 32'h0,
                     g0v[i] ? 32'h40 : (g1v[i] ? 32'h80 : 32'h0));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({r0_gnt, r1_gnt, hold} !== {e.g0, e.g1, e.hd})
                $display("FAIL tie_grant c%0d: got g0/g1/hold=%b, required %b", i,
                         {r0_gnt, r1_gnt, hold}, {e.g0, e.g1, e.hd});
            else passed++;
            if (e.cd) begin
                checks++;
                if ({r0_rd, r1_rd, mem_a} !== {e.rd0, e.rd1, e.ma})
                    $display("FAIL tie_data c%0d: got rd0=%h rd1=%h a=%h, required rd0=%h rd1=%h a=%h",
                             i, r0_rd, r1_rd, mem_a, e.rd0, e.rd1, e.ma);
                else passed++;
            end
        end
    endtask

    task automatic test_burst();
        exp_t e;
        logic g0, g1;
        do_reset();
        r0_addr = 32'h40; r1_addr = 32'h80;
        r0_req = 1; r1_req = 1;
        for (int i = 0; i < 17; i++) begin
            if (i > 0) next_cycle();
            g0 = (i > 0) && ((((i - 1) / 4) % 2) == 0);
            g1 = (i > 0) && !g0;
            push_exp(g0, g1, !g0, 1'b1, g0 ? P40 : 32'h0, g1 ? P80 : 32'h0,
                     g0 ? 32'h40 : (g1 ? 32'h80 : 32'h0));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({r0_gnt, r1_gnt, hold} !== {e.g0, e.g1, e.hd})
                $display("FAIL burst_grant c%0d: got g0/g1/hold=%b, required %b", i,
                         {r0_gnt, r1_gnt, hold}, {e.g0, e.g1, e.hd});
            else passed++;
            checks++;
            if ({r0_rd, r1_rd, mem_a} !== {e.rd0, e.rd1, e.ma})
                $display("FAIL burst_data c%0d: got rd0=%h rd1=%h a=%h, required rd0=%h rd1=%h a=%h",
                         i, r0_rd, r1_rd, mem_a, e.rd0, e.rd1, e.ma);
            else passed++;
        end
    endtask

    task automatic test_hold();
        exp_t e;
        logic [5:0] g0v = 6'b100000, g1v = 6'b011110, hdv = 6'b011110;
        do_reset();
        r0_addr = 32'h40; r1_addr = 32'h80;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_cycle();
            r1_req = 1;
            r0_req = (i >= 1);
            push_exp(g0v[i], g1v[i], hdv[i], 1'b1, g0v[i] ? P40 : 32'h0, g1v[i] ? P80 : 32'h0,
                     g0v[i] ? 32'h40 : (g1v[i] ? 32'h80 : 32'h0));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({r0_gnt, r1_gnt, hold} !== {e.g0, e.g1, e.hd})
                $display("FAIL hold_grant c%0d: got g0/g1/hold=%b, required %b", i,
                         {r0_gnt, r1_gnt, hold}, {e.g0, e.g1, e.hd});
            else passed++;
            checks++;
            if ({r0_rd, r1_rd, mem_a} !== {e.rd0, e.rd1, e.ma})
                $display("FAIL hold_data c%0d: got rd0=%h rd1=%h a=%h, required rd0=%h rd1=%h a=%h",
                         i, r0_rd, r1_rd, mem_a, e.rd0, e.rd1, e.ma);
            else passed++;
        end
    endtask

    task automatic test_lone();
        exp_t e;
        logic g0, g1;
        do_reset();
        r0_addr = 32'h40; r1_addr = 32'h80;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) next_cycle();
            r0_req = 1;
            r1_req = (i >= 10);
            g0 = (i >= 1) && (i <= 10);
            g1 = (i == 11);
            push_exp(g0, g1, !g0, 1'b1, g0 ? P40 : 32'h0, g1 ? P80 : 32'h0,
                     g0 ? 32'h40 : (g1 ? 32'h80 : 32'h0));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({r0_gnt, r1_gnt, hold} !== {e.g0, e.g1, e.hd})
                $display("FAIL lone_grant c%0d: got g0/g1/hold=%b, required %b", i,
                         {r0_gnt, r1_gnt, hold}, {e.g0, e.g1, e.hd});
            else passed++;
        end
    endtask

    task automatic test_handoff();
        exp_t e;
        int         wr_base;
        logic [5:0] g0v = 6'b000110, g1v = 6'b011000, hdv = 6'b000001;
        logic [5:0] wev = 6'b001010;
        do_reset();
        wr_base = wr_count;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_cycle();
            case (i)
                0: begin r0_req = 1; r0_we = 1; r0_addr = 32'h30; r0_wd = 32'h5555; end
                2: begin
                    r0_req = 0; r0_we = 0;
                    r1_req = 1; r1_we = 1; r1_addr = 32'h34; r1_wd = 32'h6666;
                end
                4: begin r1_req = 0; r1_we = 0; end
                default: ;
            endcase
            push_exp(g0v[i], g1v[i], hdv[i], 1'b0, 32'h0, 32'h0, 32'h0);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({r0_gnt, r1_gnt, hold} !== {e.g0, e.g1, e.hd})
                $display("FAIL handoff_grant c%0d: got g0/g1/hold=%b, required %b", i,
                         {r0_gnt, r1_gnt, hold}, {e.g0, e.g1, e.hd});
            else passed++;
            checks++;
            if (mem_we !== wev[i])
                $display("FAIL handoff_we c%0d: got mem_we=%b, required %b", i, mem_we, wev[i]);
            else passed++;
        end
        checks++;
        if ({mem[12], mem[13], 32'(wr_count - wr_base)} !== {32'h5555, 32'h6666, 32'd2})
            $display("FAIL handoff_mem: got m30=%h m34=%h writes=%0d, required 5555 6666 2",
                     mem[12], mem[13], wr_count - wr_base);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int wr_base;
        do_reset();
        wr_base = wr_count;
        r1_req = 1; r1_we = 1; r1_addr = 32'h20; r1_wd = 32'h1234;
        next_cycle();
        #1;
        checks++;
        if ({r1_gnt, mem_we, mem_a} !== {2'b11, 32'h20})
            $display("FAIL rstmid_before: got g1=%b we=%b a=%h, required 1 1 00000020", r1_gnt, mem_we, mem_a);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt, mem_we} !== 3'b000)
            $display("FAIL rstmid_drop: got g0/g1/we=%b, required 000", {r0_gnt, r1_gnt, mem_we});
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        r1_we = 0;
        checks++;
        if ({mem[8], 32'(wr_count - wr_base)} !== {P20, 32'd0})
            $display("FAIL rstmid_mem: got m20=%h writes=%0d, required %h 0", mem[8], wr_count - wr_base, P20);
        else passed++;
        r0_req = 1; r1_req = 1;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10)
            $display("FAIL rstmid_restart: got g0/g1=%b, required 10", {r0_gnt, r1_gnt});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_burst();
        test_hold();
        test_lone();
        test_handoff();
        test_reset_mid();
        do_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter wide, default 32, data width of both requester ports and the memory port.
REQ-002 SHALL have parameter burst, default 4, maximum consecutive owner cycles while the other port waits; legal range 1..255.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports r0_req / r1_req, input, 1 each, access request; port 0 is the CPU and port 1 is the coprocessor/DMA.
REQ-006 SHALL have ports r0_we / r1_we, input, 1 each, write enable qualified by req.
REQ-007 SHALL have ports r0_addr / r1_addr, input, 32 each, byte address.
REQ-008 SHALL have ports r0_wd / r1_wd, input, wide each, write data.
REQ-009 SHALL have ports r0_gnt / r1_gnt, output, 1 each, port currently owns memory.
REQ-010 SHALL have ports r0_rd / r1_rd, output, wide each, read data.
REQ-011 SHALL have port hold, output, 1, CPU stall request.
REQ-012 SHALL have ports mem_we (output, 1), mem_a (output, 32), mem_d (output, wide) and mem_q (input, wide) to a memory with combinational read and a write on the clock edge.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, OWN0 and OWN1, plus a last-owner bit and a burst counter cnt.
REQ-014 SHALL assert r0_gnt exactly when the state is OWN0 and r1_gnt exactly when the state is OWN1; the grants SHALL be mutually exclusive.
REQ-015 In IDLE, the next state SHALL be:
  - OWN of the sole requester when only one port requests;
  - OWN of the port != last when both request;
  - IDLE when neither requests.
REQ-016 Every cycle in OWNx with rx_req=1 SHALL be one access: mem_a=rx_addr, mem_d=rx_wd, mem_we=rx_we, rx_rd=mem_q in the same cycle.
REQ-017 The grant SHALL be issued one cycle after the request; a write SHALL commit on the clk edge that ends the access cycle.
REQ-018 In OWNx with rx_req=0:
  - SHALL drive mem_we=0;
  - SHALL set last=x;
  - SHALL go to OWN of the other port if it is requesting, else to IDLE.
REQ-019 In OWNx, when cnt==burst-1 and the other port is requesting, the FSM SHALL complete the current access and then switch directly to the other port's OWN state, with no IDLE bubble.
REQ-020 cnt SHALL:
  - clear on every ownership change and in IDLE;
  - increment per access otherwise;
  - saturate at burst-1 when the other port is not requesting, so a lone requester is never preempted.
REQ-021 When the state is IDLE, mem_we, mem_a and mem_d SHALL all be 0.
REQ-022 rx_rd SHALL be 0 whenever rx_gnt=0.
REQ-023 hold SHALL equal r0_req & ~r0_gnt, combinationally.
REQ-024 When a port's req falls in the same cycle the other port's req rises, the handoff SHALL follow REQ-018 with no lost or duplicated access.

Reset
REQ-025 Asserting rst SHALL immediately force:
  - state=IDLE;
  - last=1, so port 0 wins the first tie;
  - cnt=0;
  - both grants=0 and mem_we=0.
REQ-026 A reset asserted during an access SHALL suppress that write; arbitration SHALL restart per REQ-015 on the first clk edge after rst deasserts.

Structure
REQ-027 A shared package SHALL hold the state encodings (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the default wide and burst values.
REQ-028 Port steering of address, data and write enable SHALL use the existing mux2 library part; the FSM and counter SHALL be local to dmem_arb, with no other sub-module.

Verification
REQ-029 Scenario: from reset, r0 requests a write of 0xDEADBEEF to address 0x10.
  - Required: r0_gnt=1 in the next cycle with mem_we=1 and mem_a=0x10.
  - Required: a following r0 read of 0x10 returns 0xDEADBEEF.
REQ-030 Scenario: from reset, r0_req and r1_req rise together.
  - Required: OWN0 first.
  - Required: when r0_req drops, r1_gnt=1 on the next cycle with no IDLE cycle.
REQ-031 Scenario: burst=4 with both ports requesting continuously.
  - Required: grants alternate in 4-cycle blocks (0,0,0,0,1,1,1,1,...).
REQ-032 Scenario: r1 owns the memory when r0_req rises.
  - Required: hold=1 until the cycle r0_gnt=1, then hold=0.
REQ-033 Scenario: rst asserted mid-cycle during an r1 write of 0x1234 to address 0x20.
  - Required: r1_gnt and mem_we fall before the next edge.
  - Required: memory at 0x20 is unchanged.
REQ-034 Scenario: r0 alone requests for 10 cycles.
  - Required: r0_gnt stays high for all 10 cycles with no forced release.
